// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM multiplexer.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Channel index increment, wrapping 3 -> 0.
    function automatic sel_t sel_inc(sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/tdm_mux_4x1_if.sv
// Channel-side and line-side handshake bundle of the TDM multiplexer.
interface tdm_mux_4x1_if #(
    parameter int W = 1
);
    logic [W-1:0] I0, I1, I2, I3;
    logic         V0, V1, V2, V3;
    logic         R0, R1, R2, R3;
    logic [W-1:0] A;
    logic         S1, S0;
    logic         A_valid;
    logic         A_ready;

    // Valid/ready: a word moves on a rising edge where both valid and ready are
    // high; ready may depend combinationally on valid, valid never on ready.
    modport master (
        output I0, I1, I2, I3, V0, V1, V2, V3, A_ready,
        input  R0, R1, R2, R3, A, S1, S0, A_valid
    );

    modport slave (
        input  I0, I1, I2, I3, V0, V1, V2, V3, A_ready,
        output R0, R1, R2, R3, A, S1, S0, A_valid
    );
endinterface

// File: rtl/tdm_mux_4x1_rr_pick4.sv
// Combinational round-robin picker: first valid channel starting at ptr_i.
module rr_pick4
    import tdm_pkg::*;
(
    input  sel_t              ptr_i,
    input  logic [NUM_CH-1:0] v_i,
    output sel_t              g_o,
    output logic              any_valid_o
);
    sel_t idx;

    // Scan from the farthest offset back to ptr so the nearest valid wins.
    always_comb begin
        g_o         = ptr_i;
        any_valid_o = 1'b0;
        idx         = ptr_i;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr_i + sel_t'(k);
            if (v_i[idx]) begin
                g_o         = idx;
                any_valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdm_mux_4x1.sv
// Four-channel TDM multiplexer feeding a 1-to-4 demux over A and S1/S0.
// Macro TDM_SKIP_IDLE_EN selects work-conserving round-robin instead of fixed slots.
module tdm_mux_4x1
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic          clk,
    input  logic          rst,
    tdm_mux_4x1_if.slave  bus,
    output sel_t          ptr_o
);
    sel_t              ptr_q, ptr_d;
    sel_t              sel_q, sel_d;
    logic [W-1:0]      a_q, a_d;
    logic              a_valid_q, a_valid_d;
    logic              ld;
    sel_t              g;
    logic [NUM_CH-1:0] v;
    logic [NUM_CH-1:0] rdy;
    logic [W-1:0]      din [NUM_CH];

    assign v      = {bus.V3, bus.V2, bus.V1, bus.V0};
    assign din[0] = bus.I0;
    assign din[1] = bus.I1;
    assign din[2] = bus.I2;
    assign din[3] = bus.I3;

    assign ld = !a_valid_q || bus.A_ready;

`ifdef TDM_SKIP_IDLE_EN
    logic any_valid;

    rr_pick4 u_pick (
        .ptr_i       (ptr_q),
        .v_i         (v),
        .g_o         (g),
        .any_valid_o (any_valid)
    );

    // Idle cycles clear A_valid only; pointer and last word stay put.
    always_comb begin
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        a_d       = a_q;
        a_valid_d = a_valid_q;
        if (ld) begin
            a_valid_d = any_valid;
            if (any_valid) begin
                a_d   = din[g];
                sel_d = g;
                ptr_d = sel_inc(g);
            end
        end
    end
`else
    assign g = ptr_q;

    // Fixed slots: the pointer advances on every load, valid or not.
    always_comb begin
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        a_d       = a_q;
        a_valid_d = a_valid_q;
        if (ld) begin
            a_d       = din[g];
            sel_d     = g;
            a_valid_d = v[g];
            ptr_d     = sel_inc(ptr_q);
        end
    end
`endif

    always_comb begin
        rdy = '0;
        if (ld && !rst) begin
            rdy[g] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            sel_q     <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
        end
    end

    assign bus.R0      = rdy[0];
    assign bus.R1      = rdy[1];
    assign bus.R2      = rdy[2];
    assign bus.R3      = rdy[3];
    assign bus.A       = a_q;
    assign bus.S1      = sel_q[1];
    assign bus.S0      = sel_q[0];
    assign bus.A_valid = a_valid_q;
    assign ptr_o       = ptr_q;
endmodule
